// File: rtl/pwl_monitor_pkg.sv
// Shared types for PWL-input monitors: FSM state encoding, the PWL segment
// carried on a port, and the evaluation/tolerance helpers.
package pwl_monitor_pkg;
    timeunit 1ns;
    timeprecision 1ps;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TRACK   = 2'd1,
        SETTLED = 2'd2,
        TIMEOUT = 2'd3
    } mon_state_t;

    // Segment value(t) = a + b*(t - t0); fields hold IEEE-754 doubles, t in seconds.
    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] t0;
    } pwl_t;

    localparam real PWL_TSCALE = 1.0e-9;

    function automatic real pwl_eval(input pwl_t p, input real t_s);
        return $bitstoreal(p.a) + $bitstoreal(p.b) * (t_s - $bitstoreal(p.t0));
    endfunction

    // Inclusive band check; a negative tolerance collapses to an exact-match band.
    function automatic logic in_tol(input real v, input real tgt, input real tol);
        real band;
        band = (tol < 0.0) ? 0.0 : tol;
        return ((v - tgt) <= band) && ((tgt - v) <= band);
    endfunction
endpackage

// File: rtl/pwl_edge_sampler.sv
// Registers the value of a PWL segment as evaluated at each rising clock edge.
module pwl_edge_sampler
    import pwl_monitor_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  pwl_t in,
    output real  value
);
    timeunit 1ns;
    timeprecision 1ps;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            value <= 0.0;
        end else begin
            value <= pwl_eval(in, $realtime * PWL_TSCALE);
        end
    end
endmodule

// File: rtl/pwl_settle_monitor.sv
// Watches a PWL signal after a start request and reports settling within a
// tolerance band, or a timeout if it never holds the band long enough.
module pwl_settle_monitor
    import pwl_monitor_pkg::*;
#(
    parameter int N_SETTLE  = 8,
    parameter int N_TIMEOUT = 1024,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  pwl_t             in,
    input  real              target,
    input  real              tol,
    input  logic             start,
    input  logic             abort,
    output real              sample,
    output real              err,
    output logic             busy,
    output logic             settled,
    output logic             timeout,
    output logic [CNT_W-1:0] settle_cyc
);
    timeunit 1ns;
    timeprecision 1ps;

    localparam logic [CNT_W-1:0] L_SETTLE  = CNT_W'(N_SETTLE);
    localparam logic [CNT_W-1:0] L_TIMEOUT = CNT_W'(N_TIMEOUT);

    mon_state_t       r_state;
    logic [CNT_W-1:0] r_run_cnt;
    logic [CNT_W-1:0] r_cyc_cnt;
    logic [CNT_W-1:0] w_run_nxt;
    logic [CNT_W-1:0] w_cyc_nxt;

    assign w_run_nxt = (r_run_cnt >= L_SETTLE)  ? L_SETTLE  : r_run_cnt + CNT_W'(1);
    assign w_cyc_nxt = (r_cyc_cnt >= L_TIMEOUT) ? L_TIMEOUT : r_cyc_cnt + CNT_W'(1);

    pwl_edge_sampler u_sampler (
        .clk   (clk),
        .rstn  (rstn),
        .in    (in),
        .value (sample)
    );

    // Same edge-time evaluation the sampler registers, so err and the band
    // decision always agree with the sample published on this edge.
    function automatic logic f_tol_now();
        return in_tol(pwl_eval(in, $realtime * PWL_TSCALE), target, tol);
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_run_cnt  <= '0;
            r_cyc_cnt  <= '0;
            err        <= 0.0;
            busy       <= 1'b0;
            settled    <= 1'b0;
            timeout    <= 1'b0;
            settle_cyc <= '0;
        end else begin
            err <= pwl_eval(in, $realtime * PWL_TSCALE) - target;
            if (abort) begin
                r_state   <= IDLE;
                r_run_cnt <= '0;
                r_cyc_cnt <= '0;
                busy      <= 1'b0;
                settled   <= 1'b0;
                timeout   <= 1'b0;
            end else if (start) begin
                r_state    <= TRACK;
                r_run_cnt  <= '0;
                r_cyc_cnt  <= '0;
                busy       <= 1'b1;
                settled    <= 1'b0;
                timeout    <= 1'b0;
                settle_cyc <= '0;
            end else if (r_state == TRACK) begin
                r_cyc_cnt <= w_cyc_nxt;
                r_run_cnt <= f_tol_now() ? w_run_nxt : '0;
                // Settling is tested first so it wins a same-edge timeout.
                if (f_tol_now() && (w_run_nxt == L_SETTLE)) begin
                    r_state    <= SETTLED;
                    busy       <= 1'b0;
                    settled    <= 1'b1;
                    settle_cyc <= w_cyc_nxt;
                end else if (w_cyc_nxt == L_TIMEOUT) begin
                    r_state <= TIMEOUT;
                    busy    <= 1'b0;
                    timeout <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_pwl_settle_monitor.sv
// Directed bench for pwl_settle_monitor with a per-edge scoreboard of expected outputs.
module tb_pwl_settle_monitor;
    import pwl_monitor_pkg::*;
    timeunit 1ns;
    timeprecision 1ps;

    typedef struct packed {
        logic        busy;
        logic        settled;
        logic        timeout;
        logic [15:0] scyc;
        logic [63:0] samp;
        logic [63:0] errv;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    pwl_t        in;
    real         target = 0.0;
    real         tol = 0.0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    real         sample;
    real         err;
    logic        busy;
    logic        settled;
    logic        timeout;
    logic [15:0] settle_cyc;

    real  ca = 0.0, cb = 0.0, ct0 = 0.0;
    exp_t sbq[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    pwl_settle_monitor #(.N_SETTLE(8), .N_TIMEOUT(20), .CNT_W(16)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in         (in),
        .target     (target),
        .tol        (tol),
        .start      (start),
        .abort      (abort),
        .sample     (sample),
        .err        (err),
        .busy       (busy),
        .settled    (settled),
        .timeout    (timeout),
        .settle_cyc (settle_cyc)
    );

    function automatic bit near(input real x, input real y);
        return ((x - y) < 1.0e-9) && ((y - x) < 1.0e-9);
    endfunction

    task automatic chk_bit(input string tag, input logic obs, input logic expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %b, expected %b", tag, obs, expv);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    task automatic chk_real(input string tag, input real obs, input real expv);
        vectors++;
        assert (near(obs, expv) === 1'b1) else begin
            miscompares++;
            $error("FAIL %s: observed %f, expected %f", tag, obs, expv);
        end
    endtask

    task automatic set_in(input real a, input real b, input real t0);
        ca = a; cb = b; ct0 = t0;
        in.a  = $realtobits(a);
        in.b  = $realtobits(b);
        in.t0 = $realtobits(t0);
    endtask

    // Drive one edge's controls, queue what that edge must produce, then check it.
    task automatic step(input string tag, input logic s, input logic a,
                        input logic eb, input logic es, input logic et, input logic [15:0] escyc);
        exp_t e;
        real  t_edge, v;
        @(negedge clk);
        start = s;
        abort = a;
        t_edge = ($realtime + 5.0) * 1.0e-9;
        v = ca + cb * (t_edge - ct0);
        e.busy = eb; e.settled = es; e.timeout = et; e.scyc = escyc;
        e.samp = $realtobits(v);
        e.errv = $realtobits(v - target);
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk_bit({tag, ".busy"}, busy, e.busy);
        chk_bit({tag, ".settled"}, settled, e.settled);
        chk_bit({tag, ".timeout"}, timeout, e.timeout);
        chk_vec({tag, ".settle_cyc"}, settle_cyc, e.scyc);
        chk_real({tag, ".sample"}, sample, $bitstoreal(e.samp));
        chk_real({tag, ".err"}, err, $bitstoreal(e.errv));
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        set_in(0.0, 0.0, 0.0);
        #1 rstn = 1'b0;
        #1;
        chk_bit("reset.busy", busy, 1'b0);
        chk_bit("reset.settled", settled, 1'b0);
        chk_bit("reset.timeout", timeout, 1'b0);
        chk_vec("reset.settle_cyc", settle_cyc, 16'd0);
        chk_real("reset.sample", sample, 0.0);
        chk_real("reset.err", err, 0.0);
        @(negedge clk);
        rstn = 1'b1;

        // Constant on target: settles at edge 8 with settle_cyc 8.
        set_in(1.0, 0.0, 0.0); target = 1.0; tol = 0.01;
        step("t1.start", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        for (int k = 1; k <= 8; k++)
            step("t1.track", 1'b0, 1'b0, k < 8, k == 8, 1'b0, (k == 8) ? 16'd8 : 16'd0);
        step("t1.hold", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd8);

        // Ramp at 1e6/s: edge samples 0.005 + 0.01*j; abort keeps settle_cyc.
        tol = 0.05;
        set_in(0.0, 1.0e6, ($realtime + 4.0) * 1.0e-9);
        step("t2.abort", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd8);
        for (int j = 1; j < 90; j++)
            step("t2.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd8);
        step("t2.start", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        // First in-band sample (0.955) is counted edge 5; eighth in-band is edge 12.
        for (int k = 1; k <= 12; k++)
            step("t2.track", 1'b0, 1'b0, k < 12, k == 12, 1'b0, (k == 12) ? 16'd12 : 16'd0);
        step("t2.hold", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd12);

        // Never in band: timeout at edge 20, restart from SETTLED.
        set_in(0.5, 0.0, 0.0); target = 1.0; tol = 0.01;
        step("t3.start", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        for (int k = 1; k <= 20; k++)
            step("t3.track", 1'b0, 1'b0, k < 20, 1'b0, k == 20, 16'd0);
        step("t3.hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0);

        // |err| exactly equal to tol is in band.
        set_in(1.25, 0.0, 0.0); target = 1.0; tol = 0.25;
        step("t4a.start", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        for (int k = 1; k <= 8; k++)
            step("t4a.track", 1'b0, 1'b0, k < 8, k == 8, 1'b0, (k == 8) ? 16'd8 : 16'd0);

        // Negative tol clamps to zero; exact match still settles.
        set_in(1.0, 0.0, 0.0); target = 1.0; tol = -0.1;
        step("t4b.start", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        for (int k = 1; k <= 8; k++)
            step("t4b.track", 1'b0, 1'b0, k < 8, k == 8, 1'b0, (k == 8) ? 16'd8 : 16'd0);

        // Glitch at counted edge 8 restarts the run; settles at edge 16.
        tol = 0.01;
        step("t5.start", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        for (int k = 1; k <= 16; k++) begin
            if (k == 8) set_in(2.0, 0.0, 0.0);
            else        set_in(1.0, 0.0, 0.0);
            step("t5.track", 1'b0, 1'b0, k < 16, k == 16, 1'b0, (k == 16) ? 16'd16 : 16'd0);
        end

        // Abort beats start; settle_cyc held.
        step("t6.both", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd16);
        step("t6.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd16);
        step("t6.start", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        step("t6.track", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        step("t6.track", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);

        // Asynchronous reset between edges.
        #2 rstn = 1'b0;
        #1;
        chk_bit("arst.busy", busy, 1'b0);
        chk_bit("arst.settled", settled, 1'b0);
        chk_bit("arst.timeout", timeout, 1'b0);
        chk_vec("arst.settle_cyc", settle_cyc, 16'd0);
        chk_real("arst.sample", sample, 0.0);
        chk_real("arst.err", err, 0.0);
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 3; k++)
            step("arst.noresume", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);

        vectors++;
        assert (sbq.size() === 0) else begin
            miscompares++;
            $error("FAIL scoreboard.drain: observed %0d left, expected 0", sbq.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
